// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side streamer and its buffer.
package fifo_pkg;

    localparam int WIDTH_DATA_DEFAULT = 8;
    localparam int RD_BUF_DEPTH       = 2;

    typedef enum logic {
        IDLE = 1'b0,
        MID  = 1'b1
    } rd_fsm_e;

    // One stream beat at the default data width.
    typedef struct packed {
        logic [WIDTH_DATA_DEFAULT-1:0] data;
        logic                          last;
    } beat_t;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry in-order buffer holding words captured from the FIFO until the sink takes them.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH_DATA = WIDTH_DATA_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push,
    input  logic [WIDTH_DATA-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [WIDTH_DATA-1:0] head
);

    logic [WIDTH_DATA-1:0] mem_r [RD_BUF_DEPTH];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            count_r;

    // Storage, pointers and occupancy; push and pop in one cycle leave occupancy unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                mem_r[i] <= {WIDTH_DATA{1'b0}};
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fifo_rd_streamer_chk.sv
// Run-time checks on the streamer's occupancy invariant and handshake.
module fifo_rd_streamer_chk (
    input logic       clk_i,
    input logic       rst_ni,
    input logic [1:0] count,
    input logic       in_flight,
    input logic       pop,
    input logic       valid
);

    // Buffered plus in-flight words must never exceed the two buffer slots.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            a_occ: assert (({1'b0, count} + {2'b00, in_flight}) <= 3'd2);
            a_pop: assert (!pop || valid);
        end
    end

endmodule

// File: rtl/fifo_rd_streamer.sv
// FIFO read-side adapter: drives the read strobe, buffers returning words and frames them into packets.
// Optional statistics counters are enabled with FIFO_RD_STREAMER_STATS_EN.
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int WIDTH_DATA = WIDTH_DATA_DEFAULT,
    parameter int PKT_LEN_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_o,
    input  logic [WIDTH_DATA-1:0] fifo_data_i,
    input  logic [PKT_LEN_W-1:0]  pkt_len_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [WIDTH_DATA-1:0] m_data_o,
    output logic                  m_last_o
`ifdef FIFO_RD_STREAMER_STATS_EN
    ,
    output logic [31:0]           beat_cnt_o,
    output logic [15:0]           pkt_cnt_o
`endif
);

    localparam logic [PKT_LEN_W-1:0] LEN_ZERO = {PKT_LEN_W{1'b0}};
    localparam logic [PKT_LEN_W-1:0] LEN_ONE  = {{(PKT_LEN_W-1){1'b0}}, 1'b1};

    logic                  in_flight_r;
    logic [1:0]            count_s;
    logic [WIDTH_DATA-1:0] head_s;
    logic                  m_valid_s;
    logic                  pop_s;
    logic [2:0]            occ_s;
    logic                  fifo_rd_s;
    logic [PKT_LEN_W-1:0]  len_in_s;
    logic                  last_s;
    rd_fsm_e               state_r;
    rd_fsm_e               state_s;
    logic [PKT_LEN_W-1:0]  beat_cnt_r;
    logic [PKT_LEN_W-1:0]  beat_cnt_s;
    logic [PKT_LEN_W-1:0]  len_q_r;
    logic [PKT_LEN_W-1:0]  len_q_s;

    assign m_valid_s = (count_s != 2'd0);
    assign pop_s     = m_valid_s & m_ready_i;

    // The ready-to-strobe path is combinational so a slot freed this cycle can be refilled at once.
    assign occ_s     = {1'b0, count_s} + {2'b00, in_flight_r} - {2'b00, pop_s};
    assign fifo_rd_s = rst_ni & ~fifo_empty_i & (occ_s < 3'd2);
    assign fifo_rd_o = fifo_rd_s;

    // A strobe this cycle means the FIFO returns a word next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_flight_r <= 1'b0;
        end else begin
            in_flight_r <= fifo_rd_s;
        end
    end

    fifo_rd_skid_buf #(
        .WIDTH_DATA (WIDTH_DATA)
    ) u_buf (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (in_flight_r),
        .push_data (fifo_data_i),
        .pop       (pop_s),
        .count     (count_s),
        .head      (head_s)
    );

    assign len_in_s = (pkt_len_i == LEN_ZERO) ? LEN_ONE : pkt_len_i;

    // Framing next-state: a new length is sampled only when a packet's first beat leaves.
    always_comb begin
        state_s    = state_r;
        beat_cnt_s = beat_cnt_r;
        len_q_s    = len_q_r;
        last_s     = 1'b0;
        case (state_r)
            IDLE: begin
                last_s = (len_in_s == LEN_ONE);
                if (pop_s) begin
                    len_q_s = len_in_s;
                    if (last_s) begin
                        state_s    = IDLE;
                        beat_cnt_s = LEN_ZERO;
                    end else begin
                        state_s    = MID;
                        beat_cnt_s = LEN_ONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MID: begin
                last_s = (beat_cnt_r == (len_q_r - LEN_ONE));
                if (pop_s) begin
                    if (last_s) begin
                        state_s    = IDLE;
                        beat_cnt_s = LEN_ZERO;
                    end else begin
                        state_s    = MID;
                        beat_cnt_s = beat_cnt_r + LEN_ONE;
                    end
                end else begin
                    state_s = MID;
                end
            end
            default: begin
                state_s    = IDLE;
                beat_cnt_s = LEN_ZERO;
            end
        endcase
    end

    // Framing state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            beat_cnt_r <= LEN_ZERO;
            len_q_r    <= LEN_ONE;
        end else begin
            state_r    <= state_s;
            beat_cnt_r <= beat_cnt_s;
            len_q_r    <= len_q_s;
        end
    end

    assign m_valid_o = m_valid_s;
    assign m_data_o  = head_s;
    assign m_last_o  = m_valid_s & last_s;

`ifdef FIFO_RD_STREAMER_STATS_EN
    logic [31:0] stat_beats_r;
    logic [15:0] stat_pkts_r;

    // Saturating beat and packet counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_beats_r <= 32'd0;
            stat_pkts_r  <= 16'd0;
        end else begin
            if (pop_s && (stat_beats_r != 32'hFFFF_FFFF)) begin
                stat_beats_r <= stat_beats_r + 32'd1;
            end
            if (pop_s && last_s && (stat_pkts_r != 16'hFFFF)) begin
                stat_pkts_r <= stat_pkts_r + 16'd1;
            end
        end
    end

    assign beat_cnt_o = stat_beats_r;
    assign pkt_cnt_o  = stat_pkts_r;
`endif

    fifo_rd_streamer_chk u_chk (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .count     (count_s),
        .in_flight (in_flight_r),
        .pop       (pop_s),
        .valid     (m_valid_s)
    );

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a behavioural one-cycle-latency FIFO model.
module tb_fifo_rd_streamer;

    localparam int W  = 8;
    localparam int LW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          fifo_empty_i;
    logic          fifo_rd_o;
    logic [W-1:0]  fifo_data_i = 8'h00;
    logic [LW-1:0] pkt_len_i = 8'd1;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [W-1:0]  m_data_o;
    logic          m_last_o;
`ifdef FIFO_RD_STREAMER_STATS_EN
    logic [31:0]   beat_cnt_o;
    logic [15:0]   pkt_cnt_o;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [W-1:0] mem [0:2047];
    int           push_cnt = 0;
    int           pop_cnt  = 0;

    logic [W-1:0] out_data [$];
    logic         out_last [$];
    int           out_cyc  [$];

    fifo_rd_streamer #(.WIDTH_DATA(W), .PKT_LEN_W(LW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_o    (fifo_rd_o),
        .fifo_data_i  (fifo_data_i),
        .pkt_len_i    (pkt_len_i),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o),
        .m_last_o     (m_last_o)
`ifdef FIFO_RD_STREAMER_STATS_EN
        ,
        .beat_cnt_o   (beat_cnt_o),
        .pkt_cnt_o    (pkt_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    assign fifo_empty_i = (push_cnt == pop_cnt);

    // FIFO model: a reset drops its contents; read data appears the cycle after the strobe.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pop_cnt <= push_cnt;
        end else if (fifo_rd_o) begin
            fifo_data_i <= mem[pop_cnt % 2048];
            pop_cnt     <= pop_cnt + 1;
        end
    end

    // Records every accepted beat with the cycle it was taken in.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (rst_ni && m_valid_o && m_ready_i) begin
            out_data.push_back(m_data_o);
            out_last.push_back(m_last_o);
            out_cyc.push_back(cyc);
        end
    end

    task automatic push(input logic [W-1:0] w);
        mem[push_cnt % 2048] = w;
        push_cnt++;
    endtask

    task automatic clear_out();
        out_data.delete();
        out_last.delete();
        out_cyc.delete();
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int k = 0;
        while (out_data.size() < n && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        checks++;
        if (out_data.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d beats, required %0d", name, out_data.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        push(8'hEE);
        #1;
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", m_valid_o); end
        checks++; if (m_data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", m_data_o); end
        checks++; if (m_last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", m_last_o); end
        checks++; if (fifo_rd_o !== 1'b0) begin errors++; $display("FAIL reset_rd got %b exp 0", fifo_rd_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_basic();
        logic         rd_exp [6];
        logic         v_exp  [6];
        logic [W-1:0] d_exp  [6];
        logic         l_exp  [6];
        rd_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        v_exp  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        d_exp  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        l_exp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        m_ready_i = 1'b1;
        pkt_len_i = 8'd3;
        push(8'h11); push(8'h22); push(8'h33);
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (fifo_rd_o !== rd_exp[c]) begin errors++; $display("FAIL basic_rd c%0d got %b exp %b", c, fifo_rd_o, rd_exp[c]); end
            checks++; if (m_valid_o !== v_exp[c]) begin errors++; $display("FAIL basic_valid c%0d got %b exp %b", c, m_valid_o, v_exp[c]); end
            if (v_exp[c]) begin
                checks++; if (m_data_o !== d_exp[c]) begin errors++; $display("FAIL basic_data c%0d got %h exp %h", c, m_data_o, d_exp[c]); end
                checks++; if (m_last_o !== l_exp[c]) begin errors++; $display("FAIL basic_last c%0d got %b exp %b", c, m_last_o, l_exp[c]); end
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_backpressure();
        int rds = 0;
        m_ready_i = 1'b0;
        pkt_len_i = 8'd8;
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        for (int c = 0; c < 10; c++) begin
            #1;
            if (fifo_rd_o) rds++;
            @(negedge clk_i);
        end
        #1;
        checks++; if (rds !== 2) begin errors++; $display("FAIL bp_reads got %0d exp 2", rds); end
        checks++; if (fifo_rd_o !== 1'b0) begin errors++; $display("FAIL bp_rd_held got %b exp 0", fifo_rd_o); end
        checks++; if (m_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", m_valid_o); end
        checks++; if (m_data_o !== 8'hA0) begin errors++; $display("FAIL bp_head got %h exp a0", m_data_o); end
        @(negedge clk_i);
        clear_out();
        m_ready_i = 1'b1;
        wait_beats(8, 40, "bp_drain");
        for (int i = 0; i < 8 && i < out_data.size(); i++) begin
            checks++; if (out_data[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, out_data[i], 8'hA0 + 8'(i)); end
            checks++; if (out_last[i] !== (i == 7)) begin errors++; $display("FAIL bp_last[%0d] got %b exp %b", i, out_last[i], (i == 7)); end
            checks++; if (out_cyc[i] !== out_cyc[0] + i) begin errors++; $display("FAIL bp_gap[%0d] got cycle %0d exp %0d", i, out_cyc[i], out_cyc[0] + i); end
        end
    endtask

    task automatic test_len();
        logic l6 [6];
        l6 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        m_ready_i = 1'b1;
        pkt_len_i = 8'd0;
        clear_out();
        push(8'h51); push(8'h52); push(8'h53);
        wait_beats(3, 20, "len0");
        for (int i = 0; i < 3 && i < out_data.size(); i++) begin
            checks++; if (out_data[i] !== 8'h51 + 8'(i)) begin errors++; $display("FAIL len0_data[%0d] got %h exp %h", i, out_data[i], 8'h51 + 8'(i)); end
            checks++; if (out_last[i] !== 1'b1) begin errors++; $display("FAIL len0_last[%0d] got %b exp 1", i, out_last[i]); end
        end
        repeat (2) @(negedge clk_i);
        clear_out();
        pkt_len_i = 8'd4;
        for (int i = 0; i < 6; i++) push(8'h61 + 8'(i));
        wait_beats(1, 20, "lenchg_first");
        pkt_len_i = 8'd2;
        wait_beats(6, 20, "lenchg");
        for (int i = 0; i < 6 && i < out_data.size(); i++) begin
            checks++; if (out_data[i] !== 8'h61 + 8'(i)) begin errors++; $display("FAIL lenchg_data[%0d] got %h exp %h", i, out_data[i], 8'h61 + 8'(i)); end
            checks++; if (out_last[i] !== l6[i]) begin errors++; $display("FAIL lenchg_last[%0d] got %b exp %b", i, out_last[i], l6[i]); end
        end
    endtask

    task automatic test_empty_gap();
        int rds = 0;
        repeat (2) @(negedge clk_i);
        m_ready_i = 1'b1;
        pkt_len_i = 8'd4;
        clear_out();
        push(8'h71); push(8'h72);
        wait_beats(2, 20, "gap_first");
        for (int c = 0; c < 5; c++) begin
            #1;
            if (fifo_rd_o) rds++;
            @(negedge clk_i);
        end
        #1;
        checks++; if (rds !== 0) begin errors++; $display("FAIL gap_reads got %0d exp 0", rds); end
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL gap_valid got %b exp 0", m_valid_o); end
        @(negedge clk_i);
        push(8'h73); push(8'h74);
        wait_beats(4, 20, "gap_resume");
        for (int i = 0; i < 4 && i < out_data.size(); i++) begin
            checks++; if (out_data[i] !== 8'h71 + 8'(i)) begin errors++; $display("FAIL gap_data[%0d] got %h exp %h", i, out_data[i], 8'h71 + 8'(i)); end
            checks++; if (out_last[i] !== (i == 3)) begin errors++; $display("FAIL gap_last[%0d] got %b exp %b", i, out_last[i], (i == 3)); end
        end
    endtask

    task automatic test_throughput();
        repeat (2) @(negedge clk_i);
        m_ready_i = 1'b1;
        pkt_len_i = 8'd5;
        clear_out();
        for (int i = 0; i < 20; i++) push(8'h80 + 8'(i));
        wait_beats(20, 60, "tput");
        for (int i = 0; i < 20 && i < out_data.size(); i++) begin
            checks++; if (out_data[i] !== 8'h80 + 8'(i)) begin errors++; $display("FAIL tput_data[%0d] got %h exp %h", i, out_data[i], 8'h80 + 8'(i)); end
            checks++; if (out_last[i] !== ((i % 5) == 4)) begin errors++; $display("FAIL tput_last[%0d] got %b exp %b", i, out_last[i], ((i % 5) == 4)); end
        end
        if (out_cyc.size() >= 20) begin
            checks++; if (out_cyc[19] - out_cyc[0] !== 19) begin errors++; $display("FAIL tput_span got %0d cycles exp 19", out_cyc[19] - out_cyc[0]); end
        end
    endtask

    task automatic test_random();
        int pushed = 0;
        int k = 0;
        repeat (2) @(negedge clk_i);
        pkt_len_i = 8'd7;
        clear_out();
        while (out_data.size() < 1000 && k < 8000) begin
            if (pushed < 1000 && (push_cnt - pop_cnt) < 3) begin
                push(8'((pushed * 37 + 5) & 255));
                pushed++;
            end
            m_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            k++;
        end
        m_ready_i = 1'b0;
        checks++; if (out_data.size() !== 1000) begin errors++; $display("FAIL rand_count got %0d exp 1000", out_data.size()); end
        for (int i = 0; i < out_data.size() && i < 1000; i++) begin
            checks++;
            if (out_data[i] !== 8'((i * 37 + 5) & 255) || out_last[i] !== ((i % 7) == 6)) begin
                errors++;
                $display("FAIL rand_beat[%0d] got %h/%b exp %h/%b", i, out_data[i], out_last[i], 8'((i * 37 + 5) & 255), ((i % 7) == 6));
            end
        end
    endtask

    task automatic test_reset_mid();
        pkt_len_i = 8'd3;
        m_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h91 + 8'(i));
        repeat (4) @(negedge clk_i);
        m_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #2;
        checks++; if (fifo_rd_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre_rd got %b exp 1", fifo_rd_o); end
        checks++; if (m_data_o !== 8'h93) begin errors++; $display("FAIL rstmid_pre_head got %h exp 93", m_data_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", m_valid_o); end
        checks++; if (fifo_rd_o !== 1'b0) begin errors++; $display("FAIL rstmid_rd got %b exp 0", fifo_rd_o); end
        checks++; if (m_data_o !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", m_data_o); end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        pkt_len_i = 8'd1;
        @(negedge clk_i);
        clear_out();
        push(8'hB1); push(8'hB2);
        wait_beats(2, 20, "rstmid_after");
        for (int i = 0; i < 2 && i < out_data.size(); i++) begin
            checks++; if (out_data[i] !== 8'hB1 + 8'(i)) begin errors++; $display("FAIL rstmid_data[%0d] got %h exp %h", i, out_data[i], 8'hB1 + 8'(i)); end
            checks++; if (out_last[i] !== 1'b1) begin errors++; $display("FAIL rstmid_last[%0d] got %b exp 1", i, out_last[i]); end
        end
`ifdef FIFO_RD_STREAMER_STATS_EN
        @(negedge clk_i);
        checks++; if (beat_cnt_o !== 32'd2) begin errors++; $display("FAIL stats_beats got %0d exp 2", beat_cnt_o); end
        checks++; if (pkt_cnt_o !== 16'd2) begin errors++; $display("FAIL stats_pkts got %0d exp 2", pkt_cnt_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_len();
        test_empty_gap();
        test_throughput();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
